// File: rtl/evt_counter_multi.sv
// Multi-channel up/down event counter with run-time terminal count,
// per-channel wrap pulses and a coherent snapshot of all channels.
module evt_counter_multi #(
    parameter  int NUM_CH    = 4,
    parameter  int MAX_EVENT = 40000,
    parameter  int EDGE_MODE = 0,
    localparam int W         = $clog2(MAX_EVENT)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                en_in,
    input  logic [NUM_CH-1:0]   evt_in,
    input  logic [NUM_CH-1:0]   dir_in,
    input  logic [NUM_CH-1:0]   clr_in,
    input  logic [W-1:0]        term_in,
    input  logic                snap_in,
    output logic [NUM_CH*W-1:0] count_out,
    output logic [NUM_CH-1:0]   wrap_out,
    output logic [NUM_CH*W-1:0] snap_out,
    output logic                snap_valid_out
);

    localparam logic [W-1:0] T_MAX = W'(MAX_EVENT - 1);

    logic [W-1:0]      t_eff;
    logic [W-1:0]      cnt  [NUM_CH];
    logic [W-1:0]      snap [NUM_CH];
    logic [NUM_CH-1:0] prev;
    logic [NUM_CH-1:0] q;
    logic [NUM_CH-1:0] wrap;
    logic              snap_v;

    // clamp the shared terminal so counts never leave 0..MAX_EVENT-1
    always_comb begin
        t_eff = (term_in > T_MAX) ? T_MAX : term_in;
    end

    // event qualification: level, or rising edge against last cycle
    always_comb begin
        q = (EDGE_MODE != 0) ? (evt_in & ~prev) : evt_in;
    end

    // edge history tracks the raw input unconditionally
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            prev <= '0;
        end else begin
            prev <= evt_in;
        end
    end

    // per-channel count and wrap pulse; clear beats enable beats event
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            wrap <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                wrap[i] <= 1'b0;
                if (clr_in[i]) begin
                    cnt[i] <= '0;
                end else if (en_in && q[i]) begin
                    if (!dir_in[i]) begin
                        if (cnt[i] >= t_eff) begin
                            cnt[i]  <= '0;
                            wrap[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end else begin
                        if (cnt[i] == '0) begin
                            cnt[i]  <= t_eff;
                            wrap[i] <= 1'b1;
                        end else if (cnt[i] > t_eff) begin
                            cnt[i] <= t_eff;
                        end else begin
                            cnt[i] <= cnt[i] - 1'b1;
                        end
                    end
                end
            end
        end
    end

    // snapshot captures pre-update counts and flags it next cycle
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap[i] <= '0;
            end
            snap_v <= 1'b0;
        end else begin
            snap_v <= snap_in;
            if (snap_in) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    snap[i] <= cnt[i];
                end
            end
        end
    end

    // flatten channel arrays onto the packed output buses
    always_comb begin
        count_out = '0;
        snap_out  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            count_out[i*W +: W] = cnt[i];
            snap_out[i*W +: W]  = snap[i];
        end
        wrap_out       = wrap;
        snap_valid_out = snap_v;
    end

endmodule

// File: tb/tb_evt_counter_multi.sv
// Scoreboard bench: level- and edge-mode instances share stimulus,
// a behavioural model queues expectations, a monitor checks them.
module tb_evt_counter_multi;

    localparam int NC = 4;
    localparam int ME = 40000;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [NC-1:0] evt = '0;
    logic [NC-1:0] dir = '0;
    logic [NC-1:0] clr = '0;
    logic [W-1:0]  term = '0;
    logic          snp = 1'b0;

    logic [NC*W-1:0] c_lvl, c_edg, s_lvl, s_edg;
    logic [NC-1:0]   w_lvl, w_edg;
    logic            v_lvl, v_edg;

    always #5 clk = ~clk;

    evt_counter_multi #(.NUM_CH(NC), .MAX_EVENT(ME), .EDGE_MODE(0)) u_lvl (
        .clk_in(clk), .rst_in(rst), .en_in(en), .evt_in(evt),
        .dir_in(dir), .clr_in(clr), .term_in(term), .snap_in(snp),
        .count_out(c_lvl), .wrap_out(w_lvl), .snap_out(s_lvl),
        .snap_valid_out(v_lvl)
    );

    evt_counter_multi #(.NUM_CH(NC), .MAX_EVENT(ME), .EDGE_MODE(1)) u_edg (
        .clk_in(clk), .rst_in(rst), .en_in(en), .evt_in(evt),
        .dir_in(dir), .clr_in(clr), .term_in(term), .snap_in(snp),
        .count_out(c_edg), .wrap_out(w_edg), .snap_out(s_edg),
        .snap_valid_out(v_edg)
    );

    typedef struct {
        logic [NC*W-1:0] c [2];
        logic [NC-1:0]   w [2];
        logic            sv;
        logic [NC*W-1:0] s [2];
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // model state: counts per mode/channel, shared edge history, snapshots
    int m_cnt [2][NC];
    int m_snp [2][NC];
    bit m_prev [NC];

    task automatic chk(input string name, input logic [NC*W-1:0] act,
                       input logic [NC*W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < NC; i++) begin
                m_cnt[m][i] = 0;
                m_snp[m][i] = 0;
            end
        for (int i = 0; i < NC; i++) m_prev[i] = 0;
    endtask

    // one clock of stimulus: drive at negedge, queue the post-edge view
    task automatic cycle(input bit e, input logic [NC-1:0] ev,
                         input logic [NC-1:0] d, input logic [NC-1:0] c,
                         input logic [W-1:0] tm, input bit sn);
        exp_t x;
        int t;
        bit q;
        @(negedge clk);
        en = e; evt = ev; dir = d; clr = c; term = tm; snp = sn;
        t = (int'(tm) > ME - 1) ? ME - 1 : int'(tm);
        for (int m = 0; m < 2; m++) begin
            x.w[m] = '0;
            if (sn)
                for (int i = 0; i < NC; i++) m_snp[m][i] = m_cnt[m][i];
            for (int i = 0; i < NC; i++) begin
                q = (m == 0) ? ev[i] : (ev[i] && !m_prev[i]);
                if (c[i]) begin
                    m_cnt[m][i] = 0;
                end else if (e && q) begin
                    if (!d[i]) begin
                        if (m_cnt[m][i] + 1 > t) begin
                            m_cnt[m][i] = 0;
                            x.w[m][i] = 1'b1;
                        end else begin
                            m_cnt[m][i] += 1;
                        end
                    end else if (m_cnt[m][i] == 0) begin
                        m_cnt[m][i] = t;
                        x.w[m][i] = 1'b1;
                    end else begin
                        m_cnt[m][i] = (m_cnt[m][i] - 1 < t) ? m_cnt[m][i] - 1 : t;
                    end
                end
            end
            for (int i = 0; i < NC; i++) begin
                x.c[m][i*W +: W] = W'(m_cnt[m][i]);
                x.s[m][i*W +: W] = W'(m_snp[m][i]);
            end
        end
        for (int i = 0; i < NC; i++) m_prev[i] = ev[i];
        x.sv = sn;
        exp_q.push_back(x);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cnt_lvl"}, c_lvl, '0);
        chk({tag, "_cnt_edg"}, c_edg, '0);
        chk({tag, "_wrap"}, {w_lvl, w_edg}, '0);
        chk({tag, "_snap_lvl"}, s_lvl, '0);
        chk({tag, "_snap_edg"}, s_edg, '0);
        chk({tag, "_sv"}, {v_lvl, v_edg}, '0);
    endtask

    // async reset between edges, outputs checked before any clock
    task automatic mid_reset();
        @(negedge clk);
        en = 0; evt = '0; clr = '0; snp = 0;
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // monitor: pop one expectation per post-edge sample
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("count_lvl", c_lvl, x.c[0]);
                chk("count_edg", c_edg, x.c[1]);
                chk("wrap_lvl", NC*W'(w_lvl), NC*W'(x.w[0]));
                chk("wrap_edg", NC*W'(w_edg), NC*W'(x.w[1]));
                chk("snap_valid", {v_lvl, v_edg}, {x.sv, x.sv});
                if (x.sv || v_lvl || v_edg) begin
                    chk("snap_lvl", s_lvl, x.s[0]);
                    chk("snap_edg", s_edg, x.s[1]);
                end
            end
        end
    end

    initial begin
        logic [W-1:0]  rt;
        logic [NC-1:0] rd;
        int budget;
        model_reset();
        #3 chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // ch0 up, T=9, held high 12 cycles
        for (int k = 0; k < 12; k++) cycle(1, 4'b0001, 4'b0000, 4'b0000, 16'd9, 0);
        // ch1 down from 0, T=4, three events
        cycle(1, 4'b0000, 4'b0010, 4'b1111, 16'd4, 0);
        for (int k = 0; k < 3; k++) cycle(1, 4'b0010, 4'b0010, 4'b0000, 16'd4, 0);
        // held high, low, high again: two edges
        cycle(1, 4'b0000, 4'b0000, 4'b1111, 16'd9, 0);
        for (int k = 0; k < 5; k++) cycle(1, 4'b0001, 4'b0000, 4'b0000, 16'd9, 0);
        cycle(1, 4'b0000, 4'b0000, 4'b0000, 16'd9, 0);
        cycle(1, 4'b0001, 4'b0000, 4'b0000, 16'd9, 0);
        // ch2 to 7 then clear with a coincident event
        cycle(1, 4'b0000, 4'b0000, 4'b1111, 16'd9, 0);
        for (int k = 0; k < 7; k++) cycle(1, 4'b0100, 4'b0000, 4'b0000, 16'd9, 0);
        cycle(1, 4'b0100, 4'b0000, 4'b0100, 16'd9, 0);
        // disabled: events ignored
        for (int k = 0; k < 4; k++) cycle(0, 4'b1111, 4'b0000, 4'b0000, 16'd9, 0);
        // ch3 at 30, terminal lowered: up wraps, down clamps
        cycle(1, 4'b0000, 4'b0000, 4'b1111, 16'd40, 0);
        for (int k = 0; k < 30; k++) cycle(1, 4'b1000, 4'b0000, 4'b0000, 16'd40, 0);
        cycle(1, 4'b1000, 4'b0000, 4'b0000, 16'd10, 0);
        cycle(1, 4'b0000, 4'b0000, 4'b1111, 16'd40, 0);
        for (int k = 0; k < 30; k++) cycle(1, 4'b1000, 4'b0000, 4'b0000, 16'd40, 0);
        cycle(1, 4'b1000, 4'b1000, 4'b0000, 16'd10, 0);
        // oversized terminal clamps to MAX_EVENT-1
        cycle(1, 4'b0000, 4'b1111, 4'b1111, 16'hFFFF, 0);
        cycle(1, 4'b1111, 4'b1111, 4'b0000, 16'hFFFF, 0);
        cycle(1, 4'b0000, 4'b0000, 4'b0000, 16'hFFFF, 0);
        cycle(1, 4'b1111, 4'b0000, 4'b0000, 16'hFFFF, 0);
        // T=0 up: wrap every event
        for (int k = 0; k < 3; k++) cycle(1, 4'b1111, 4'b0000, 4'b1111 & {4{k == 0}}, 16'd0, 0);
        // snapshot while counting, back-to-back, then reset with pulse pending
        cycle(1, 4'b0000, 4'b0000, 4'b1111, 16'd20, 0);
        for (int k = 0; k < 5; k++) cycle(1, 4'b0001, 4'b0000, 4'b0000, 16'd20, 0);
        cycle(1, 4'b0001, 4'b0000, 4'b0000, 16'd20, 1);
        cycle(1, 4'b0001, 4'b0000, 4'b0000, 16'd20, 1);
        cycle(1, 4'b0000, 4'b0000, 4'b0000, 16'd20, 1);
        mid_reset();

        // randomized run
        rt = 16'd7;
        rd = '0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 19) == 0)
                rt = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(39990, 65535))
                                                  : 16'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) rd = 4'($urandom);
            if (k == 1000) mid_reset();
            cycle($urandom_range(0, 9) != 0, 4'($urandom), rd,
                  4'($urandom) & 4'($urandom) & 4'($urandom),
                  rt, $urandom_range(0, 7) == 0);
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
